systolic_tile_engine: RTL and testbench
=======================================

SYSTOLIC_TILE_ENGINE -- requirements
Module: systolic_tile_engine

Interface
REQ-001 Parameters: N default 4 (PE array dim); WIDTH default 16 (signed data width); ADDR_W default 12 (word address width); DIM_W default 9 (matrix-size width).
REQ-002 Ports, in order: clk, input, 1, single clock, rising edge; rst, input, 1, synchronous, active-high.
REQ-003 Control ports: start, input, 1, operation request; stepping_enable, input, 1; step, input, 1, single-step pulse; relu_en, input, 1.
REQ-004 Operand ports: addr_A, addr_B, addr_C, input, ADDR_W, unsigned base word addresses of row-major n×n matrices; n, input, DIM_W, unsigned matrix size.
REQ-005 Memory ports: mem_addr, output, ADDR_W; mem_wren, output, 1; mem_wdata, output, WIDTH, signed; mem_rdata, input, WIDTH, signed, 1-cycle read latency.
REQ-006 Status ports: busy, output, 1; done, output, 1; overflow, output, 1, sticky; error_code, output, error_code_t; fsm_state, output, state_t.
REQ-007 Counter ports: total_cycles, output, 32; reads_count, output, 32; writes_count, output, 32.

Function
REQ-008 Computes C = A·B for any 1 ≤ n ≤ 2^DIM_W−1, tiling C into ceil(n/N)² N×N output tiles, row-major tile order.
REQ-009 States: IDLE, LOAD_A, LOAD_B, WAIT, MAC, WRITE, DONE, ERROR.
REQ-010 IDLE: start=1 with n=0 -> ERROR, error_code=ERR_SIZE; any region end (base+n²−1) ≥ 2^ADDR_W -> ERROR, ERR_RANGE; otherwise LOAD_A with tile (0,0), k=0, accumulators cleared.
REQ-011 Per k-step: LOAD_A N cycles (issue A[tileRow·N+r][k], r=0..N−1); LOAD_B N cycles (issue B[k][tileCol·N+c]); WAIT 1 cycle; MAC 1 cycle, acc[r][c] += a[r]·b[c]; cost 2N+2 cycles.
REQ-012 Read data is captured the cycle after its address issue.
REQ-013 Out-of-range rows/cols (index ≥ n): no read issued, captured operand forced to 0, not counted in reads_count.
REQ-014 After MAC with k=n−1 -> WRITE: N² cycles, one element per cycle, row-major; mem_wren=1 only for in-range elements at addr_C + row·n + col.
REQ-015 Accumulator width 2·WIDTH+DIM_W; write value saturates to signed WIDTH range; any saturation sets overflow.
REQ-016 If relu_en=1, negative results are written as 0 (applied after saturation).
REQ-017 After last tile's WRITE -> DONE: done=1 for exactly one cycle, then IDLE; overflow and counters hold until next accepted start.
REQ-018 ERROR holds until start=1, which re-evaluates as in IDLE.
REQ-019 stepping_enable=1: the FSM and all counters except total_cycles advance only in cycles with step=1; no memory write occurs in a stalled cycle.
REQ-020 start while busy is ignored.
REQ-021 busy=1 in LOAD_A, LOAD_B, WAIT, MAC and WRITE; total_cycles increments every busy cycle.

Reset
REQ-022 rst=1 forces IDLE; all outputs 0; error_code=ERR_NONE; accumulators and counters cleared; takes effect mid-operation on the next edge with no further memory write.

Configuration
REQ-023 SYSTOLIC_RELU_EN defined: REQ-016 active. Undefined: relu_en is ignored and no ReLU logic is built.

Structure
REQ-024 state_t and error_code_t (ERR_NONE, ERR_SIZE, ERR_RANGE) belong in the shared SystolicTypes package.
REQ-025 One sub-module, systolic_mac_row: N signed MACs with clear/enable; instantiated N times.

Verification
REQ-026 n=4, N=4, A=identity, B=1..16 -> C=B; total_cycles=56; reads_count=32; writes_count=16; done pulses once.
REQ-027 n=5, N=4, A=B=all 1 -> every C element = 5; total_cycles=264; reads_count=100; writes_count=25; no write outside the 25 words.
REQ-028 WIDTH=16, n=2, A=B=all 32767 -> every C element = 32767; overflow=1; A=all 32767, B=all −32768 -> every C element = −32768.
REQ-029 Build with SYSTOLIC_RELU_EN, relu_en=1, A=−identity, B=all 3 -> C=all 0; build without it -> C=all −3.
REQ-030 n=0 -> ERROR, ERR_SIZE, no memory access; addr_C=4090, n=4 -> ERR_RANGE; rst mid-WRITE -> IDLE next cycle, mem_wren=0.
REQ-031 stepping_enable=1, step pulsed every 3rd cycle -> results identical to free-running; reads_count and writes_count unchanged.

Source files
------------

// File: rtl/systolic_tile_engine_pkg.sv
// Shared types for the systolic tile engine: FSM state and error codes.
package SystolicTypes;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    MAC    = 3'd4,
    WRITE  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SIZE  = 2'd1,
    ERR_RANGE = 2'd2
  } error_code_t;

  // Counter width for 0..count-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/systolic_tile_engine_mac_row.sv
// One row of the PE array: N signed multiply-accumulators sharing the row operand a.
module systolic_mac_row #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 41
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic [N-1:0][WIDTH-1:0]     b,
  output logic [N-1:0][ACC_W-1:0]     acc
);

  localparam int unsigned PW = 2 * WIDTH;

  logic signed [PW-1:0]     a_ext;
  logic [N-1:0][PW-1:0]     prod;
  logic [N-1:0][ACC_W-1:0]  prod_ext;

  // Sign-extend operands to product width so the low PW bits are the exact product.
  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    for (int c = 0; c < N; c++) begin
      prod[c]     = a_ext * $signed({{WIDTH{b[c][WIDTH-1]}}, b[c]});
      prod_ext[c] = {{(ACC_W - PW){prod[c][PW-1]}}, prod[c]};
    end
  end

  // Accumulate on enable; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      for (int c = 0; c < N; c++) begin
        acc[c] <= acc[c] + prod_ext[c];
      end
    end
  end

endmodule

// File: rtl/systolic_tile_engine.sv
// Tiled N x N systolic matrix multiplier C = A*B over a single-port word memory.
// Optional build macro SYSTOLIC_RELU_EN enables clamping negative results to zero.
module systolic_tile_engine
  import SystolicTypes::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIM_W  = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stepping_enable,
  input  logic                     step,
  input  logic                     relu_en,
  input  logic [ADDR_W-1:0]        addr_A,
  input  logic [ADDR_W-1:0]        addr_B,
  input  logic [ADDR_W-1:0]        addr_C,
  input  logic [DIM_W-1:0]         n,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wren,
  output logic signed [WIDTH-1:0]  mem_wdata,
  input  logic signed [WIDTH-1:0]  mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output error_code_t              error_code,
  output state_t                   fsm_state,
  output logic [31:0]              total_cycles,
  output logic [31:0]              reads_count,
  output logic [31:0]              writes_count
);

  localparam int unsigned ACC_W = 2 * WIDTH + DIM_W;
  localparam int unsigned IW    = idx_width(N);
  localparam int unsigned EW    = idx_width(N * N);

  state_t                   state_q;
  error_code_t              err_q;
  logic [ADDR_W-1:0]        a_base_q, b_base_q, c_base_q;
  logic [DIM_W-1:0]         n_q, tiles_q, tr_q, tc_q, k_q;
  logic [IW-1:0]            idx_q;
  logic [EW-1:0]            el_q;
  logic                     ovf_q;
  logic [31:0]              tot_q, rd_q, wr_q;

  logic [N-1:0][WIDTH-1:0]  a_q, b_q;
  logic                     pend_q, pend_b_q, pend_zero_q;
  logic [IW-1:0]            pend_idx_q;

  logic [N-1:0][N-1:0][ACC_W-1:0] acc;

  logic                     adv, issue, rd_inrange, wr_inrange, range_bad, sat_hit;
  logic                     mac_clr, mac_en, last_el;
  logic [31:0]              rd_row, rd_col, wr_row_g, wr_col_g, n_sq, addr_lim;
  logic [IW-1:0]            wr_row, wr_col;
  logic [DIM_W-1:0]         tiles_new;
  logic [ACC_W-1:0]         wr_acc;
  logic [WIDTH-1:0]         wr_val;

  // A stalled cycle (stepping without a step pulse) freezes the FSM and event counters.
  assign adv     = !stepping_enable || step;
  assign issue   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign last_el = (el_q == EW'(N * N - 1));
  assign mac_en  = (state_q == MAC) && adv;
  assign mac_clr = (adv && start && ((state_q == IDLE) || (state_q == ERROR))) ||
                   ((state_q == WRITE) && adv && last_el);

  // Start-time validation: region ends and tile count.
  always_comb begin
    n_sq      = 32'(n) * 32'(n);
    addr_lim  = 32'd1 << ADDR_W;
    range_bad = (32'(addr_A) + n_sq - 32'd1 >= addr_lim) ||
                (32'(addr_B) + n_sq - 32'd1 >= addr_lim) ||
                (32'(addr_C) + n_sq - 32'd1 >= addr_lim);
    tiles_new = DIM_W'((32'(n) + N - 1) / N);
  end

  // Address generation for operand reads and result writes.
  always_comb begin
    rd_row     = 32'(tr_q) * N + 32'(idx_q);
    rd_col     = 32'(tc_q) * N + 32'(idx_q);
    wr_row     = IW'(32'(el_q) / N);
    wr_col     = IW'(32'(el_q) % N);
    wr_row_g   = 32'(tr_q) * N + 32'(wr_row);
    wr_col_g   = 32'(tc_q) * N + 32'(wr_col);
    wr_inrange = (wr_row_g < 32'(n_q)) && (wr_col_g < 32'(n_q));
    rd_inrange = 1'b0;
    mem_addr   = '0;
    case (state_q)
      LOAD_A: begin
        rd_inrange = rd_row < 32'(n_q);
        if (rd_inrange) mem_addr = ADDR_W'(32'(a_base_q) + rd_row * 32'(n_q) + 32'(k_q));
      end
      LOAD_B: begin
        rd_inrange = rd_col < 32'(n_q);
        if (rd_inrange) mem_addr = ADDR_W'(32'(b_base_q) + 32'(k_q) * 32'(n_q) + rd_col);
      end
      WRITE: begin
        if (wr_inrange) mem_addr = ADDR_W'(32'(c_base_q) + wr_row_g * 32'(n_q) + wr_col_g);
      end
      default: ;
    endcase
  end

  // Saturate the selected accumulator to WIDTH bits, then optionally clamp negatives.
  always_comb begin
    wr_acc  = acc[wr_row][wr_col];
    sat_hit = wr_acc[ACC_W-1:WIDTH-1] != {(ACC_W - WIDTH + 1){wr_acc[ACC_W-1]}};
    if (sat_hit) begin
      wr_val = wr_acc[ACC_W-1] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
    end else begin
      wr_val = wr_acc[WIDTH-1:0];
    end
`ifdef SYSTOLIC_RELU_EN
    if (relu_en && wr_val[WIDTH-1]) wr_val = '0;
`endif
  end

`ifndef SYSTOLIC_RELU_EN
  logic unused_relu;
  assign unused_relu = relu_en;
`endif

  assign mem_wren     = (state_q == WRITE) && wr_inrange && adv && !rst;
  assign mem_wdata    = ((state_q == WRITE) && wr_inrange) ? wr_val : '0;
  assign busy         = issue || (state_q == WAIT) || (state_q == MAC) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign overflow     = ovf_q;
  assign error_code   = err_q;
  assign fsm_state    = state_q;
  assign total_cycles = tot_q;
  assign reads_count  = rd_q;
  assign writes_count = wr_q;

  // Main controller: tile/k/element sequencing, status and event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= ERR_NONE;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      n_q      <= '0;
      tiles_q  <= '0;
      tr_q     <= '0;
      tc_q     <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      el_q     <= '0;
      ovf_q    <= 1'b0;
      tot_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      if (busy) tot_q <= tot_q + 32'd1;
      if (state_q == DONE) begin
        // Not gated by stepping so done is always a single-cycle pulse.
        state_q <= IDLE;
      end else if (adv) begin
        case (state_q)
          IDLE, ERROR: begin
            if (start) begin
              a_base_q <= addr_A;
              b_base_q <= addr_B;
              c_base_q <= addr_C;
              n_q      <= n;
              tiles_q  <= tiles_new;
              tr_q     <= '0;
              tc_q     <= '0;
              k_q      <= '0;
              idx_q    <= '0;
              el_q     <= '0;
              ovf_q    <= 1'b0;
              tot_q    <= '0;
              rd_q     <= '0;
              wr_q     <= '0;
              if (n == '0) begin
                state_q <= ERROR;
                err_q   <= ERR_SIZE;
              end else if (range_bad) begin
                state_q <= ERROR;
                err_q   <= ERR_RANGE;
              end else begin
                state_q <= LOAD_A;
                err_q   <= ERR_NONE;
              end
            end
          end
          LOAD_A, LOAD_B: begin
            if (rd_inrange) rd_q <= rd_q + 32'd1;
            if (idx_q == IW'(N - 1)) begin
              idx_q   <= '0;
              state_q <= (state_q == LOAD_A) ? LOAD_B : WAIT;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
          WAIT: state_q <= MAC;
          MAC: begin
            if (k_q == n_q - DIM_W'(1)) begin
              el_q    <= '0;
              state_q <= WRITE;
            end else begin
              k_q     <= k_q + DIM_W'(1);
              state_q <= LOAD_A;
            end
          end
          WRITE: begin
            if (wr_inrange) begin
              wr_q <= wr_q + 32'd1;
              if (sat_hit) ovf_q <= 1'b1;
            end
            if (last_el) begin
              el_q <= '0;
              k_q  <= '0;
              if (tc_q == tiles_q - DIM_W'(1)) begin
                tc_q <= '0;
                if (tr_q == tiles_q - DIM_W'(1)) begin
                  state_q <= DONE;
                end else begin
                  tr_q    <= tr_q + DIM_W'(1);
                  state_q <= LOAD_A;
                end
              end else begin
                tc_q    <= tc_q + DIM_W'(1);
                state_q <= LOAD_A;
              end
            end else begin
              el_q <= el_q + EW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Operand capture one cycle after issue; runs every cycle since the memory
  // returns data for the previous address regardless of stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_b_q    <= 1'b0;
      pend_zero_q <= 1'b0;
      pend_idx_q  <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      if (pend_q) begin
        if (pend_b_q) b_q[pend_idx_q] <= pend_zero_q ? '0 : mem_rdata;
        else          a_q[pend_idx_q] <= pend_zero_q ? '0 : mem_rdata;
      end
      pend_q      <= issue && adv;
      pend_b_q    <= (state_q == LOAD_B);
      pend_idx_q  <= idx_q;
      pend_zero_q <= !rd_inrange;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    systolic_mac_row #(
      .N     (N),
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (a_q[r]),
      .b   (b_q),
      .acc (acc[r])
    );
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Scoreboard bench for systolic_tile_engine with a matrix-level reference model.
module tb_systolic_tile_engine;
  import SystolicTypes::*;

  localparam int N      = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 9;
`ifdef SYSTOLIC_RELU_EN
  localparam bit RELU_BUILT = 1'b1;
`else
  localparam bit RELU_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, stepping_enable, step, relu_en;
  logic [ADDR_W-1:0] addr_A, addr_B, addr_C, mem_addr;
  logic [DIM_W-1:0] n;
  logic mem_wren, busy, done, overflow;
  logic signed [WIDTH-1:0] mem_wdata, mem_rdata;
  error_code_t error_code;
  state_t fsm_state;
  logic [31:0] total_cycles, reads_count, writes_count;

  logic pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic signed [WIDTH-1:0] pre_data;

  always #5 clk = ~clk;

  systolic_tile_engine #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stepping_enable(stepping_enable), .step(step),
    .relu_en(relu_en), .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .n(n),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .overflow(overflow), .error_code(error_code),
    .fsm_state(fsm_state), .total_cycles(total_cycles), .reads_count(reads_count),
    .writes_count(writes_count)
  );

  // Word memory with 1-cycle read latency; bench preload port has priority.
  logic signed [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wren) mem[mem_addr] <= mem_wdata;
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;

  function automatic void check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  // Monitor: every DUT write must match the next expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Step pulse every third cycle; only matters when stepping_enable is set.
  initial begin : stepper
    int cnt;
    cnt  = 0;
    step = 1'b0;
    forever begin
      @(posedge clk); #1;
      cnt++;
      step = (cnt % 3 == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind 0: v*identity, 1: all v, 2: 1..nn*nn, 3: random in [-v, v]
  task automatic fill(input int base, input int nn, input int kind, input int v);
    int x;
    for (int i = 0; i < nn; i++) begin
      for (int j = 0; j < nn; j++) begin
        case (kind)
          0:       x = (i == j) ? v : 0;
          1:       x = v;
          2:       x = i * nn + j + 1;
          default: x = int'($urandom_range(0, 2 * v)) - v;
        endcase
        @(posedge clk); #1;
        pre_we   = 1'b1;
        pre_addr = ADDR_W'(base + i * nn + j);
        pre_data = WIDTH'(x);
      end
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  int c_model[$];
  int m_reads, m_total;
  bit m_ovf;

  // Reference: plain matrix product, saturation, optional ReLU, tile-order write list.
  task automatic build_model(input int nn, input int aa, input int ab, input int ac,
                             input bit relu);
    longint s;
    int tiles, rows, cols, gi, gj;
    wr_t w;
    c_model.delete();
    m_ovf   = 1'b0;
    m_reads = 0;
    for (int i = 0; i < nn; i++) begin
      for (int j = 0; j < nn; j++) begin
        s = 0;
        for (int k = 0; k < nn; k++) s += longint'(mem[aa + i * nn + k]) * longint'(mem[ab + k * nn + j]);
        if (s > 32767) begin s = 32767; m_ovf = 1'b1; end
        else if (s < -32768) begin s = -32768; m_ovf = 1'b1; end
        if (RELU_BUILT && relu && s < 0) s = 0;
        c_model.push_back(int'(s));
      end
    end
    tiles = (nn + N - 1) / N;
    for (int tr = 0; tr < tiles; tr++) begin
      for (int tc = 0; tc < tiles; tc++) begin
        rows = (nn - tr * N < N) ? nn - tr * N : N;
        cols = (nn - tc * N < N) ? nn - tc * N : N;
        m_reads += (rows + cols) * nn;
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            gi = tr * N + r;
            gj = tc * N + c;
            if (gi < nn && gj < nn) begin
              w.addr = ac + gi * nn + gj;
              w.data = c_model[gi * nn + gj];
              exp_q.push_back(w);
            end
          end
        end
      end
    end
    m_total = tiles * tiles * (nn * (2 * N + 2) + N * N);
  endtask

  task automatic run_op(input string nm, input int nn, input int aa, input int ab, input int ac,
                        input bit relu, input bit stp);
    int base, bad;
    bit got, seen;
    build_model(nn, aa, ab, ac, relu);
    @(posedge clk); #1;
    addr_A = ADDR_W'(aa); addr_B = ADDR_W'(ab); addr_C = ADDR_W'(ac);
    n = DIM_W'(nn); relu_en = relu; stepping_enable = stp; start = 1'b1;
    base = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      got = busy;
    end
    start = 1'b0;
    check({nm, " started"}, got, 1);
    seen = 1'b0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout: done not seen within cycle budget", nm);
      exp_q.delete();
      return;
    end
    check({nm, " reads_count"}, reads_count, m_reads);
    check({nm, " writes_count"}, writes_count, nn * nn);
    if (!stp) check({nm, " total_cycles"}, total_cycles, m_total);
    check({nm, " overflow"}, overflow, m_ovf);
    check({nm, " error_code"}, error_code, ERR_NONE);
    repeat (2) @(negedge clk);
    check({nm, " done_pulses"}, done_cnt - base, 1);
    check({nm, " back_to_idle"}, fsm_state, IDLE);
    check({nm, " pending_writes"}, exp_q.size(), 0);
    check({nm, " counters_hold"}, writes_count, nn * nn);
    bad = 0;
    for (int i = 0; i < nn * nn; i++) if (int'(mem[ac + i]) != c_model[i]) bad++;
    check({nm, " c_mismatches"}, bad, 0);
  endtask

  initial begin
    int nn;
    bit got;
    rst = 1'b1; start = 1'b0; stepping_enable = 1'b0; relu_en = 1'b0;
    addr_A = '0; addr_B = '0; addr_C = '0; n = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst state", fsm_state, IDLE);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst overflow", overflow, 0);
    check("rst error_code", error_code, ERR_NONE);
    check("rst total", total_cycles, 0);
    check("rst reads", reads_count, 0);
    check("rst writes", writes_count, 0);
    check("rst mem_wren", mem_wren, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // C = I*B
    fill(0, 4, 0, 1);
    fill(100, 4, 2, 0);
    run_op("ident4", 4, 0, 100, 200, 1'b0, 1'b0);

    // Partial edge tiles
    fill(0, 5, 1, 1);
    fill(100, 5, 1, 1);
    run_op("ones5", 5, 0, 100, 200, 1'b0, 1'b0);
    run_op("ones5_step", 5, 0, 100, 300, 1'b0, 1'b1);

    // Saturation both ways
    fill(0, 2, 1, 32767);
    fill(100, 2, 1, 32767);
    run_op("sat_pos", 2, 0, 100, 200, 1'b0, 1'b0);
    fill(100, 2, 1, -32768);
    run_op("sat_neg", 2, 0, 100, 200, 1'b0, 1'b0);

    // ReLU (effective only in a SYSTOLIC_RELU_EN build)
    fill(0, 4, 0, -1);
    fill(100, 4, 1, 3);
    run_op("relu", 4, 0, 100, 200, 1'b1, 1'b0);

    // Randomised sizes and data
    for (int t = 0; t < 4; t++) begin
      nn = int'($urandom_range(1, 9));
      fill(10, nn, 3, 300);
      fill(500, nn, 3, 300);
      run_op("rand", nn, 10, 500, 1000 + t, 1'($urandom_range(0, 1)), 1'b0);
    end
    fill(10, 3, 3, 32768);
    fill(500, 3, 3, 32768);
    run_op("rand_full", 3, 10, 500, 1000, 1'b0, 1'b0);
    nn = int'($urandom_range(2, 7));
    fill(10, nn, 3, 500);
    fill(500, nn, 3, 500);
    run_op("rand_step", nn, 10, 500, 1500, 1'b0, 1'b1);

    // Size error
    @(posedge clk); #1;
    stepping_enable = 1'b0; n = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("size state", fsm_state, ERROR);
    check("size code", error_code, ERR_SIZE);
    check("size busy", busy, 0);
    check("size reads", reads_count, 0);

    // Range error, re-evaluated from ERROR
    addr_A = 12'd0; addr_B = 12'd100; addr_C = 12'd4090; n = 9'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("range state", fsm_state, ERROR);
    check("range code", error_code, ERR_RANGE);
    check("range reads", reads_count, 0);

    // Valid start straight out of ERROR
    fill(0, 4, 2, 0);
    fill(100, 4, 0, 1);
    run_op("after_err", 4, 0, 100, 200, 1'b0, 1'b0);

    // Reset in the middle of WRITE
    build_model(4, 0, 100, 300, 1'b0);
    @(posedge clk); #1;
    addr_C = 12'd300; n = 9'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = (fsm_state == WRITE);
    end
    check("midwr reached_write", got, 1);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midwr state", fsm_state, IDLE);
    check("midwr mem_wren", mem_wren, 0);
    check("midwr busy", busy, 0);
    check("midwr writes", writes_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midwr idle_after", fsm_state, IDLE);
    check("midwr no_write_after", mem_wren, 0);
    exp_q.delete();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
